// File: rtl/useq_pkg.sv
// useq_pkg: control word types, microaddresses and microword builder for micro_sequencer
package useq_pkg;
    localparam int UA_W = 5;
    typedef logic [UA_W-1:0] uaddr_t;
    localparam uaddr_t S_FETCH    = 5'd0;
    localparam uaddr_t S_DECODE   = 5'd1;
    localparam uaddr_t S_MEMADR   = 5'd2;
    localparam uaddr_t S_MEMREAD  = 5'd3;
    localparam uaddr_t S_MEMWB    = 5'd4;
    localparam uaddr_t S_MEMWRITE = 5'd5;
    localparam uaddr_t S_EXECUTER = 5'd6;
    localparam uaddr_t S_EXECUTEI = 5'd7;
    localparam uaddr_t S_ALUWB    = 5'd8;
    localparam uaddr_t S_BRANCH   = 5'd9;
    localparam uaddr_t S_BL       = 5'd10;
    localparam uaddr_t S_MEMREADB = 5'd11;
    localparam uaddr_t ILL_LO     = 5'd12;
    localparam uaddr_t ILL_HI     = 5'd29;
    localparam uaddr_t DISPATCH2  = 5'd30;
    localparam uaddr_t DISPATCH1  = 5'd31;
    typedef struct packed {
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       ir_write;
        logic       byte_en;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       mem_access;
    } ctrl_t;
    typedef struct packed {
        ctrl_t  ctl;
        uaddr_t next;
    } uinstr_t;
    function automatic uinstr_t uw(input logic [4:0] we, input logic adr, input logic [1:0] a, input logic [1:0] b,
                                   input logic [1:0] r, input logic [1:0] o, input logic [1:0] i, input logic ma,
                                   input uaddr_t nx);
        return '{ctl: ctrl_t'({we, adr, a, b, r, o, i, ma}), next: nx};
    endfunction
    function automatic logic is_illegal(input uaddr_t a);
        return a >= ILL_LO && a <= ILL_HI;
    endfunction
endpackage

// File: rtl/useq_next_addr.sv
// useq_next_addr: resolves literal, dispatch-1 (decode) and dispatch-2 (memory) microaddresses
module useq_next_addr
    import useq_pkg::*;
#(
    parameter uaddr_t FETCH_UADDR = S_FETCH
) (
    input  logic [UA_W-1:0] next_field,
    input  logic [1:0]      op,
    input  logic [5:0]      funct,
    input  logic            cond_ex,
    output logic [UA_W-1:0] next_addr
);
    logic [UA_W-1:0] d1, d2;
    logic unused_funct;
    assign unused_funct = ^{funct[3], funct[1]};
    assign d1 = !cond_ex ? FETCH_UADDR :
                op == 2'b01 ? S_MEMADR :
                op == 2'b10 ? (funct[4] ? S_BL : S_BRANCH) :
                funct[5] ? S_EXECUTEI : S_EXECUTER;
    assign d2 = funct[0] ? (funct[2] ? S_MEMREADB : S_MEMREAD) : S_MEMWRITE;
    assign next_addr = next_field == DISPATCH1 ? d1 : next_field == DISPATCH2 ? d2 : next_field;
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: microcoded multicycle ARM control unit; define USEQ_ILLEGAL_TRAP_EN for the illegal-uPC trap
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int                 UADDR_W     = UA_W,
    parameter logic [UADDR_W-1:0] FETCH_UADDR = '0,
    parameter int                 MAX_WAIT    = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic               cond_ex,
    input  logic               mem_ready,
    output logic               mem_req,
    output ctrl_t              ctrl,
    output logic [UADDR_W-1:0] upc,
`ifdef USEQ_ILLEGAL_TRAP_EN
    output logic               illegal_upc,
`endif
    output logic               mem_timeout
);
    localparam int WW = MAX_WAIT > 1 ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] MW = WW'(MAX_WAIT);
    uinstr_t ui;
    logic [UADDR_W-1:0] nxt;
    logic [WW-1:0] wait_cnt;
    logic stall, hold;
    always_comb begin
        case (upc)
            S_FETCH:    ui = uw(5'b10010, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b1, S_DECODE);
            S_DECODE:   ui = uw(5'b00000, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, DISPATCH1);
            S_MEMADR:   ui = uw(5'b00000, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, DISPATCH2);
            S_MEMREAD:  ui = uw(5'b00000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, S_MEMWB);
            S_MEMWB:    ui = uw(5'b01000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0, FETCH_UADDR);
            S_MEMWRITE: ui = uw(5'b00100, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, FETCH_UADDR);
            S_EXECUTER: ui = uw(5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, S_ALUWB);
            S_EXECUTEI: ui = uw(5'b00000, 1'b0, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0, S_ALUWB);
            S_ALUWB:    ui = uw(5'b01000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, FETCH_UADDR);
            S_BRANCH:   ui = uw(5'b10000, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 1'b0, FETCH_UADDR);
            S_BL:       ui = uw(5'b11000, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 1'b0, FETCH_UADDR);
            S_MEMREADB: ui = uw(5'b00001, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, S_MEMWB);
            default:    ui = uw(5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, FETCH_UADDR);
        endcase
    end
    assign mem_req = ui.ctl.mem_access;
    assign stall = mem_req & ~mem_ready;
    assign hold = stall | ~reset_n;
    useq_next_addr #(.FETCH_UADDR(FETCH_UADDR)) u_next (
        .next_field(ui.next),
        .op(op),
        .funct(funct),
        .cond_ex(cond_ex),
        .next_addr(nxt)
    );
    always_comb begin
        ctrl = ui.ctl;
        ctrl.pc_write = ui.ctl.pc_write & ~hold;
        ctrl.reg_write = ui.ctl.reg_write & ~hold;
        ctrl.mem_write = ui.ctl.mem_write & ~hold;
        ctrl.ir_write = ui.ctl.ir_write & ~hold;
`ifdef USEQ_ILLEGAL_TRAP_EN
        if (is_illegal(upc)) ctrl = '0;
`endif
    end
    // the timeout flag is sticky; the sequencer keeps waiting for mem_ready regardless
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upc <= FETCH_UADDR;
            wait_cnt <= '0;
            mem_timeout <= 1'b0;
        end else if (stall) begin
            wait_cnt <= wait_cnt == MW ? wait_cnt : wait_cnt + 1'b1;
            mem_timeout <= mem_timeout | (MAX_WAIT != 0 && wait_cnt == MW - 1'b1);
        end else begin
            upc <= nxt;
            wait_cnt <= '0;
        end
    end
`ifdef USEQ_ILLEGAL_TRAP_EN
    logic ill_q;
    assign illegal_upc = ill_q | is_illegal(upc);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ill_q <= 1'b0;
        else ill_q <= illegal_upc;
    end
`endif
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed and randomized checks of micro_sequencer against a path-level reference model
module tb_micro_sequencer;
    import useq_pkg::*;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] op = 2'b00;
    logic [5:0] funct = 6'b0;
    logic cond_ex = 1'b1;
    logic mem_ready = 1'b1;
    logic mem_req, mem_timeout;
    ctrl_t ctrl;
    logic [4:0] upc;
`ifdef USEQ_ILLEGAL_TRAP_EN
    logic illegal_upc;
`endif
    int vectors = 0;
    int miscompares = 0;
    int obs_upc[$];
    logic [4:0] obs_we[$];
    bit obs_req[$], obs_rdy[$], obs_to[$];
    int path[$];
    bit m_sticky = 0;
    int m_run = 0;
    // write enables {pc, reg, mem, ir, byte} and memory-access flag per state 0..11
    logic [4:0] we_tab [12] = '{5'b10010, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b00100,
                                5'b00000, 5'b00000, 5'b01000, 5'b10000, 5'b11000, 5'b00001};
    bit acc_tab [12] = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1};

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk(clk),
        .reset_n(reset_n),
        .op(op),
        .funct(funct),
        .cond_ex(cond_ex),
        .mem_ready(mem_ready),
        .mem_req(mem_req),
        .ctrl(ctrl),
        .upc(upc),
`ifdef USEQ_ILLEGAL_TRAP_EN
        .illegal_upc(illegal_upc),
`endif
        .mem_timeout(mem_timeout)
    );

    function automatic logic [4:0] we_of(input ctrl_t c);
        return {c.pc_write, c.reg_write, c.mem_write, c.ir_write, c.byte_en};
    endfunction

    function automatic string utrace();
        string s = "";
        foreach (obs_upc[n]) s = n ? $sformatf("%s,%0d", s, obs_upc[n]) : $sformatf("%0d", obs_upc[n]);
        return s;
    endfunction

    function automatic string wtrace(input int b);
        string s = "";
        foreach (obs_we[n]) s = $sformatf("%s%0b", s, obs_we[n][b]);
        return s;
    endfunction

    function automatic string rtrace();
        string s = "";
        foreach (obs_req[n]) s = $sformatf("%s%0b", s, obs_req[n]);
        return s;
    endfunction

    task automatic ref_path(input logic [1:0] o, input logic [5:0] f, input logic c);
        path = '{0, 1};
        if (!c) return;
        if (o == 2'b01) begin
            path.push_back(2);
            path.push_back(f[0] ? (f[2] ? 11 : 3) : 5);
            if (f[0]) path.push_back(4);
        end else if (o == 2'b10) path.push_back(f[4] ? 10 : 9);
        else begin
            path.push_back(f[5] ? 7 : 6);
            path.push_back(8);
        end
    endtask

    // runs one instruction from FETCH back to FETCH, recording one entry per cycle
    task automatic exec(input logic [1:0] o, input logic [5:0] f, input logic c,
                        input int st_state, input int st_n, input bit rnd);
        int k = 0;
        bit left = 0;
        obs_upc.delete(); obs_we.delete(); obs_req.delete(); obs_rdy.delete(); obs_to.delete();
        op = o; funct = f; cond_ex = c;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (int'(upc) == st_state && k < st_n) begin
                mem_ready = 1'b0;
                k++;
            end else mem_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            obs_upc.push_back(int'(upc));
            obs_we.push_back(we_of(ctrl));
            obs_req.push_back(mem_req);
            obs_rdy.push_back(mem_ready);
            obs_to.push_back(mem_timeout);
            if (upc != 5'd0) left = 1;
            else if (left) return;
            @(negedge clk);
        end
        vectors++;
        miscompares++;
        $display("FAIL exec_bound: upc=%0d never returned to fetch within 200 cycles, required a return", upc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (upc !== 5'd0 || mem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: upc=%0d timeout=%0b, required upc=0 timeout=0", upc, mem_timeout);
        end
        vectors++;
        if (we_of(ctrl) !== 5'b0 || ctrl.mem_access !== 1'b1 || mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ctrl: we=%b mem_access=%b mem_req=%b, required we=00000 mem_access=1 mem_req=1",
                     we_of(ctrl), ctrl.mem_access, mem_req);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        exec(2'b00, 6'b000100, 1'b1, -1, 0, 1'b0);
        vectors++;
        if (utrace() != "0,1,6,8,0") begin
            miscompares++;
            $display("FAIL add_upc: got %s, required 0,1,6,8,0", utrace());
        end
        vectors++;
        if (wtrace(3) != "00010") begin
            miscompares++;
            $display("FAIL add_reg_write: got %s, required 00010", wtrace(3));
        end
    endtask

    task automatic test_ldr_stall();
        exec(2'b01, 6'b011001, 1'b1, 3, 3, 1'b0);
        vectors++;
        if (utrace() != "0,1,2,3,3,3,3,4,0") begin
            miscompares++;
            $display("FAIL ldr_upc: got %s, required 0,1,2,3,3,3,3,4,0", utrace());
        end
        vectors++;
        if (rtrace() != "100111101") begin
            miscompares++;
            $display("FAIL ldr_mem_req: got %s, required 100111101", rtrace());
        end
        vectors++;
        if (wtrace(3) != "000000010") begin
            miscompares++;
            $display("FAIL ldr_reg_write: got %s, required 000000010", wtrace(3));
        end
    endtask

    task automatic test_ldrb_str();
        exec(2'b01, 6'b011101, 1'b1, -1, 0, 1'b0);
        vectors++;
        if (utrace() != "0,1,2,11,4,0" || wtrace(0) != "000100") begin
            miscompares++;
            $display("FAIL ldrb: upc %s byte_en %s, required upc 0,1,2,11,4,0 byte_en 000100", utrace(), wtrace(0));
        end
        exec(2'b01, 6'b011000, 1'b1, 5, 2, 1'b0);
        vectors++;
        if (utrace() != "0,1,2,5,5,5,0") begin
            miscompares++;
            $display("FAIL str_upc: got %s, required 0,1,2,5,5,5,0", utrace());
        end
        vectors++;
        if (wtrace(2) != "0000010") begin
            miscompares++;
            $display("FAIL str_mem_write: got %s, required 0000010", wtrace(2));
        end
    endtask

    task automatic test_branches();
        exec(2'b10, 6'b010000, 1'b1, -1, 0, 1'b0);
        vectors++;
        if (utrace() != "0,1,10,0") begin
            miscompares++;
            $display("FAIL bl_upc: got %s, required 0,1,10,0", utrace());
        end
        vectors++;
        if (wtrace(4) != "1011" || wtrace(3) != "0010") begin
            miscompares++;
            $display("FAIL bl_writes: pc %s reg %s, required pc 1011 reg 0010", wtrace(4), wtrace(3));
        end
        exec(2'b10, 6'b000000, 1'b1, -1, 0, 1'b0);
        vectors++;
        if (utrace() != "0,1,9,0") begin
            miscompares++;
            $display("FAIL b_upc: got %s, required 0,1,9,0", utrace());
        end
        vectors++;
        if (wtrace(4) != "1011" || wtrace(3) != "0000") begin
            miscompares++;
            $display("FAIL b_writes: pc %s reg %s, required pc 1011 reg 0000", wtrace(4), wtrace(3));
        end
    endtask

    task automatic test_cond_fail();
        exec(2'b00, 6'b000100, 1'b0, -1, 0, 1'b0);
        vectors++;
        if (utrace() != "0,1,0") begin
            miscompares++;
            $display("FAIL cond_upc: got %s, required 0,1,0", utrace());
        end
        vectors++;
        if (obs_we.size() < 2 || obs_we[1] !== 5'b0) begin
            miscompares++;
            $display("FAIL cond_writes: decode writes %b, required 00000", obs_we.size() > 1 ? obs_we[1] : 5'bx);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [1:0] o = 2'($urandom_range(0, 3));
            logic [5:0] f = 6'($urandom);
            logic c = ($urandom_range(0, 4) != 0);
            int i = 0;
            exec(o, f, c, -1, 0, 1'b1);
            ref_path(o, f, c);
            for (int n = 0; n < obs_upc.size(); n++) begin
                int s = (i < path.size()) ? path[i] : 0;
                bit st;
                vectors++;
                if (obs_upc[n] !== s || obs_to[n] !== m_sticky) begin
                    miscompares++;
                    $display("FAIL rand_upc: t=%0d cyc=%0d upc=%0d timeout=%0b, required upc=%0d timeout=%0b",
                             t, n, obs_upc[n], obs_to[n], s, m_sticky);
                end
                if (i >= path.size()) break;
                st = acc_tab[s] && !obs_rdy[n];
                vectors++;
                if (obs_we[n] !== (st ? (we_tab[s] & 5'b00001) : we_tab[s]) || obs_req[n] !== acc_tab[s]) begin
                    miscompares++;
                    $display("FAIL rand_ctrl: t=%0d cyc=%0d state=%0d we=%b req=%b, required we=%b req=%b",
                             t, n, s, obs_we[n], obs_req[n], st ? (we_tab[s] & 5'b00001) : we_tab[s], acc_tab[s]);
                end
                if (st) begin
                    m_run++;
                    if (m_run == 15) m_sticky = 1;
                end else begin
                    m_run = 0;
                    i++;
                end
            end
            vectors++;
            if (i != path.size()) begin
                miscompares++;
                $display("FAIL rand_len: t=%0d reached %0d of %0d states", t, i, path.size());
            end
        end
    endtask

    task automatic test_timeout();
        string ir_exp = "";
        repeat (20) ir_exp = {ir_exp, "0"};
        ir_exp = {ir_exp, "10001"};
        exec(2'b00, 6'b000100, 1'b1, 0, 20, 1'b0);
        vectors++;
        if (utrace() != "0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,6,8,0") begin
            miscompares++;
            $display("FAIL to_upc: got %s, required twenty-one 0s then 1,6,8,0", utrace());
        end
        vectors++;
        if (wtrace(1) != ir_exp) begin
            miscompares++;
            $display("FAIL to_ir_write: got %s, required %s", wtrace(1), ir_exp);
        end
        vectors++;
        if (obs_to.size() != 25 || obs_to[14] !== m_sticky || obs_to[15] !== 1'b1 || obs_to[24] !== 1'b1) begin
            miscompares++;
            $display("FAIL to_flag: at 14/15/24 got %0b/%0b/%0b, required %0b/1/1",
                     obs_to.size() > 14 ? obs_to[14] : 1'bx, obs_to.size() > 15 ? obs_to[15] : 1'bx,
                     obs_to.size() > 24 ? obs_to[24] : 1'bx, m_sticky);
        end
        m_sticky = 1;
        m_run = 0;
    endtask

    task automatic test_reset_mid_write();
        int guard = 0;
        op = 2'b01; funct = 6'b011000; cond_ex = 1'b1; mem_ready = 1'b1;
        while (upc != 5'd5 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        vectors++;
        if (upc !== 5'd5 || ctrl.mem_write !== 1'b1 || mem_timeout !== m_sticky) begin
            miscompares++;
            $display("FAIL rst_pre: upc=%0d mem_write=%b timeout=%b, required upc=5 mem_write=1 timeout=%b",
                     upc, ctrl.mem_write, mem_timeout, m_sticky);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (upc !== 5'd0 || ctrl.mem_write !== 1'b0 || we_of(ctrl) !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_mid: upc=%0d we=%b, required upc=0 we=00000", upc, we_of(ctrl));
        end
        vectors++;
        if (mem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_timeout: got %b, required 0", mem_timeout);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_sticky = 0;
        m_run = 0;
    endtask

`ifdef USEQ_ILLEGAL_TRAP_EN
    task automatic test_trap();
        mem_ready = 1'b1;
        force dut.upc = 5'd17;
        #1;
        vectors++;
        if (illegal_upc !== 1'b1 || ctrl !== ctrl_t'(0)) begin
            miscompares++;
            $display("FAIL trap_enter: illegal=%b ctrl=%h, required illegal=1 ctrl=0", illegal_upc, ctrl);
        end
        release dut.upc;
        @(negedge clk);
        #1;
        vectors++;
        if (upc !== 5'd0 || illegal_upc !== 1'b1) begin
            miscompares++;
            $display("FAIL trap_exit: upc=%0d illegal=%b, required upc=0 illegal=1", upc, illegal_upc);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_ldr_stall();
        test_ldrb_str();
        test_branches();
        test_cond_fail();
        test_random();
        test_timeout();
        test_reset_mid_write();
`ifdef USEQ_ILLEGAL_TRAP_EN
        test_trap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microcoded control unit for the multicycle ARM datapath.
- Holds the micro-PC (uPC) and reads a 32-entry internal control store.
- Resolves the next microaddress: literal, dispatch-1 (decode) or dispatch-2 (memory).
- Stalls on a memory ready/request handshake and drives every datapath enable/select each cycle.

Parameters:
- UADDR_W, 5, uPC / next-address width; the control store has 2**UADDR_W entries.
- FETCH_UADDR, 0, uPC value after reset and after any return to fetch.
- MAX_WAIT, 15, stall-cycle limit before mem_timeout asserts (0 disables the limit).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  2  instr[27:26].
- funct  in  6  instr[25:20].
- cond_ex  in  1  condition check passed (valid in DECODE).
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  current microinstruction performs a memory access.
- ctrl  out  ctrl_t  datapath control word (packed struct, see Decomposition).
- upc  out  UADDR_W  current uPC (debug).
- mem_timeout  out  1  sticky flag: a stall exceeded MAX_WAIT.

Behaviour:
- uPC register and wait counter are async-cleared by reset_n=0: upc=FETCH_UADDR, wait_cnt=0, mem_timeout=0.
- ctrl and mem_req are combinational from upc, so control for a uPC is valid in the same cycle (0 latency).
- During reset, ctrl is the FETCH word with every write enable forced to 0.
- Control store states (fixed encoding):
  - 0 FETCH: ir_write, pc_write, mem_access; next 1.
  - 1 DECODE: next 31.
  - 2 MEMADR: next 30.
  - 3 MEMREAD: mem_access; next 4.
  - 4 MEMWB: reg_write; next 0.
  - 5 MEMWRITE: mem_write, mem_access; next 0.
  - 6 EXECUTER, 7 EXECUTEI: next 8.
  - 8 ALUWB: reg_write; next 0.
  - 9 BRANCH: pc_write; next 0.
  - 10 BL: pc_write, reg_write(LR); next 0.
  - 11 MEMREADB: byte_en, mem_access; next 4.
- Dispatch-1 (next=31), first match wins:
  - op=01 -> 2.
  - op=10 with funct[4]=0 -> 9; with funct[4]=1 -> 10.
  - otherwise funct[5]=1 -> 7, else 6.
- Dispatch-2 (next=30):
  - funct[0]=1 -> (funct[2] ? 11 : 3).
  - funct[0]=0 -> 5.
- Condition fail: in DECODE with cond_ex=0, next = FETCH_UADDR. Dispatch is skipped; no writes issued.
- Handshake:
  - mem_req = mem_access bit of the current word.
  - While mem_req=1 and mem_ready=0: uPC holds, and pc_write, ir_write, mem_write and reg_write are masked to 0 in ctrl.
  - The advance and the unmasked writes happen in the cycle mem_ready=1.
  - mem_ready is ignored when mem_req=0.
- wait_cnt:
  - Increments each stalled cycle; clears on advance.
  - When it reaches MAX_WAIT (if MAX_WAIT≠0), mem_timeout sets. It stays set until reset; the sequencer keeps waiting.
  - wait_cnt saturates at MAX_WAIT and never wraps.
- Unused entries 12..29: all-zero control word, next = FETCH_UADDR.
- Reset asserted mid-access: uPC returns to FETCH immediately; no write enable is driven.

Optional Feature:
- Macro: USEQ_ILLEGAL_TRAP_EN.
- Defined:
  - Entering uPC 12..29 sets a sticky output illegal_upc (extra port, 1 bit, reset 0) and forces ctrl to zero.
  - The next uPC is FETCH_UADDR; illegal_upc clears only on reset.
- Undefined:
  - No illegal_upc port; entries behave as stated above.

Decomposition:
- Package useq_pkg holds:
  - ctrl_t packed struct: pc_write, reg_write, mem_write, ir_write, byte_en, adr_src, alu_src_a[1:0], alu_src_b[1:0], result_src[1:0], alu_op[1:0], imm_src[1:0], mem_access.
  - uinstr_t: ctrl_t plus next[UADDR_W-1:0].
  - localparams for the state addresses and for DISPATCH1=31 and DISPATCH2=30.
- Natural sub-module: useq_next_addr, the combinational dispatch resolver (next field, op, funct, cond_ex -> resolved address).
- useq_ctrl_rom (case-statement control store) stays inline.

Test Plan:
- ADD register (op=00, funct=000100), cond_ex=1, mem_ready=1 -> upc sequence 0,1,6,8,0; reg_write is 1 only in the ALUWB cycle.
- LDR (op=01, funct=011001), mem_ready low for 3 cycles in MEMREAD:
  - upc sequence 0,1,2,3,3,3,3,4,0.
  - mem_req=1 throughout state 3; reg_write is 1 only in state 4.
- LDRB (funct[2]=1, funct[0]=1) -> dispatch to 11 with byte_en=1. STR (funct[0]=0) -> 5 with mem_write=1 only on the mem_ready cycle.
- Branches:
  - op=10, funct[4]=1 -> upc 0,1,10,0 with pc_write and reg_write in state 10.
  - op=10, funct[4]=0 -> state 9.
  - cond_ex=0 in DECODE -> upc 0,1,0 with no writes.
- MAX_WAIT=15, mem_ready held 0 in FETCH for 20 cycles:
  - mem_timeout rises after 15 stalled cycles and remains 1 after mem_ready returns.
  - upc holds 0, and ir_write stays 0 until mem_ready=1.
- reset_n pulsed low mid-MEMWRITE (asynchronous, between clock edges):
  - upc goes to 0 immediately and mem_write drops to 0.
- With USEQ_ILLEGAL_TRAP_EN defined, forcing upc to 17 sets illegal_upc=1 and returns to 0 on the next cycle.
